// File: rtl/key_debounce_multi_pkg.sv
// Shared defaults and helpers for the multi-channel key debouncer.
// Defaults assume a 24 MHz system clock: 10 ms debounce, 50 ms long press.
package key_debounce_multi_pkg;

  localparam int DEF_DEB_CYCLES  = 240_000;
  localparam int DEF_HOLD_CYCLES = 1_200_000;

  // Per-channel one-cycle event pulses.
  typedef struct packed {
    logic press;
    logic rel;
    logic hold;
  } key_evt_t;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_multi_ch.sv
// One key channel: 2-flop synchroniser, stable-level debounce counter,
// long-press counter and registered press/release/hold pulses.
module key_debounce_ch
  import key_debounce_multi_pkg::*;
#(
  parameter int   DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int   HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter logic ACTIVE_LVL  = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_i,
  output logic key_o,
  output logic key_press,
  output logic key_rel,
  output logic key_hold
);

  localparam int DEB_W  = clog2(DEB_CYCLES);
  localparam int HOLD_W = clog2(HOLD_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 2);
  localparam logic              IDLE_LVL = ~ACTIVE_LVL;

  logic              r_sync1;
  logic              r_sync2;
  logic [DEB_W-1:0]  r_cnt;
  logic              r_key;
  logic [HOLD_W-1:0] r_hcnt;
  key_evt_t          r_evt;

  logic w_diff;
  logic w_accept;
  logic w_pressed;
  logic w_release;

  assign w_diff    = (r_sync2 != r_key);
  assign w_accept  = w_diff && (r_cnt == DEB_LAST);
  assign w_pressed = (r_key == ACTIVE_LVL);
  assign w_release = w_accept && w_pressed;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1 <= IDLE_LVL;
      r_sync2 <= IDLE_LVL;
      r_cnt   <= '0;
      r_key   <= IDLE_LVL;
      r_hcnt  <= '0;
      r_evt   <= '0;
    end else begin
      r_sync1 <= key_i;
      r_sync2 <= r_sync1;

      // Any return to the current level cancels the pending change.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= '0;
        r_key <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_evt.press <= w_accept && !w_pressed;
      r_evt.rel   <= w_release;

      // Clearing on the release edge keeps key_hold and key_rel mutually exclusive.
      if (!w_pressed || w_release) begin
        r_hcnt     <= '0;
        r_evt.hold <= 1'b0;
      end else begin
        if (r_hcnt != HOLD_SAT) begin
          r_hcnt <= r_hcnt + 1'b1;
        end
        r_evt.hold <= (r_hcnt == HOLD_PRE);
      end
    end
  end

  assign key_o     = r_key;
  assign key_press = r_evt.press;
  assign key_rel   = r_evt.rel;
  assign key_hold  = r_evt.hold;

endmodule

// File: rtl/key_debounce_multi.sv
// N independent debounced key channels with press, release and long-press pulses.
// Sits between the board key pins and the control FSMs.
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int   CH          = 4,
  parameter int   DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int   HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter logic ACTIVE_LVL  = 1'b0
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [CH-1:0] key_i,
  output logic [CH-1:0] key_o,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_rel,
  output logic [CH-1:0] key_hold
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .ACTIVE_LVL  (ACTIVE_LVL)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .key_i     (key_i[g]),
      .key_o     (key_o[g]),
      .key_press (key_press[g]),
      .key_rel   (key_rel[g]),
      .key_hold  (key_hold[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi (CH=2, DEB_CYCLES=4, HOLD_CYCLES=10, active-low).
// Expected pulse events are queued with their cycle stamp; a monitor pops and compares them.
module tb_key_debounce_multi;

  localparam int CH   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int LAT  = DEB + 2;
  localparam int W    = 24;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic [CH-1:0] key_i   = 2'b00;
  logic [CH-1:0] key_o;
  logic [CH-1:0] key_press;
  logic [CH-1:0] key_rel;
  logic [CH-1:0] key_hold;

  key_debounce_multi #(
    .CH          (CH),
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .ACTIVE_LVL  (1'b0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_i     (key_i),
    .key_o     (key_o),
    .key_press (key_press),
    .key_rel   (key_rel),
    .key_hold  (key_hold)
  );

  // Clock and cycle stamp
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] mk(input int stamp, input logic [1:0] p,
                                      input logic [1:0] r, input logic [1:0] h,
                                      input logic [1:0] ko);
    logic [15:0] s;
    s = stamp[15:0];
    return {s, p, r, h, ko};
  endfunction

  task automatic push_ev(input int stamp, input logic [1:0] p, input logic [1:0] r,
                         input logic [1:0] h, input logic [1:0] ko);
    exp_q.push_back(mk(stamp, p, r, h, ko));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Monitor: every cycle with a pulse must match the next queued event
  logic [W-1:0] m_act;
  logic [W-1:0] m_exp;
  always @(negedge sys_clk) begin
    if (|{key_press, key_rel, key_hold}) begin
      m_act = mk(cyc, key_press, key_rel, key_hold, key_o);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got stamp=%0d p=%b r=%b h=%b ko=%b, required no pulse",
                 m_act[23:8], m_act[7:6], m_act[5:4], m_act[3:2], m_act[1:0]);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_act !== m_exp) begin
          bad++;
          $display("FAIL pulse_event: got stamp=%0d p=%b r=%b h=%b ko=%b, required stamp=%0d p=%b r=%b h=%b ko=%b",
                   m_act[23:8], m_act[7:6], m_act[5:4], m_act[3:2], m_act[1:0],
                   m_exp[23:8], m_exp[7:6], m_exp[5:4], m_exp[3:2], m_exp[1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int c;

    // 1 Reset: asynchronous assertion, checked before any clock edge
    #1 sys_rst = 1'b1;
    #1;
    check("reset_async_key_o", 32'(key_o), 32'h3);
    check("reset_async_pulses", 32'({key_press, key_rel, key_hold}), 32'h0);
    tick(3);
    check("reset_held_key_o", 32'(key_o), 32'h3);
    key_i = 2'b11;
    tick(1);
    sys_rst = 1'b0;
    tick(4);
    check("idle_key_o", 32'(key_o), 32'h3);

    // 2 Clean press ch0, released after 6 cycles pressed (no hold)
    c = cyc;
    key_i = 2'b10;
    push_ev(c + LAT, 2'b01, 2'b00, 2'b00, 2'b10);
    tick(LAT - 1);
    check("press_not_early", 32'(key_o), 32'h3);
    tick(1);
    check("press_key_o", 32'(key_o), 32'h2);
    c = cyc;
    key_i = 2'b11;
    push_ev(c + LAT, 2'b00, 2'b01, 2'b00, 2'b11);
    tick(LAT + 4);

    // 3 Bounce: low 3, high 1, then low held
    key_i = 2'b10;
    tick(3);
    key_i = 2'b11;
    tick(1);
    c = cyc;
    key_i = 2'b10;
    push_ev(c + LAT, 2'b01, 2'b00, 2'b00, 2'b10);
    tick(LAT - 1);
    check("bounce_not_early", 32'(key_o), 32'h3);
    tick(1);
    c = cyc;
    key_i = 2'b11;
    push_ev(c + LAT, 2'b00, 2'b01, 2'b00, 2'b11);
    tick(LAT + 4);

    // 3b Two-cycle glitch alone: no change, no pulse
    key_i = 2'b10;
    tick(2);
    key_i = 2'b11;
    tick(LAT + 4);
    check("glitch_key_o", 32'(key_o), 32'h3);

    // 4 Long press ch1: hold 9 cycles after key_o falls, then release
    c = cyc;
    key_i = 2'b01;
    push_ev(c + LAT, 2'b10, 2'b00, 2'b00, 2'b01);
    push_ev(c + LAT + 9, 2'b00, 2'b00, 2'b10, 2'b01);
    tick(20);
    check("long_key_o", 32'(key_o), 32'h1);
    c = cyc;
    key_i = 2'b11;
    push_ev(c + LAT, 2'b00, 2'b10, 2'b00, 2'b11);
    tick(LAT + 4);

    // 4b Release after 5 cycles pressed: no hold
    c = cyc;
    key_i = 2'b01;
    push_ev(c + LAT, 2'b10, 2'b00, 2'b00, 2'b01);
    tick(5);
    key_i = 2'b11;
    push_ev(c + LAT + 5, 2'b00, 2'b10, 2'b00, 2'b11);
    tick(LAT + 6);

    // 4c Release accepted on the very cycle hold would fire: release only
    c = cyc;
    key_i = 2'b01;
    push_ev(c + LAT, 2'b10, 2'b00, 2'b00, 2'b01);
    tick(9);
    key_i = 2'b11;
    push_ev(c + LAT + 9, 2'b00, 2'b10, 2'b00, 2'b11);
    tick(LAT + 6);

    // 5 Both channels pressed and released together
    c = cyc;
    key_i = 2'b00;
    push_ev(c + LAT, 2'b11, 2'b00, 2'b00, 2'b00);
    tick(LAT);
    c = cyc;
    key_i = 2'b11;
    push_ev(c + LAT, 2'b00, 2'b11, 2'b00, 2'b11);
    tick(LAT + 4);

    // 5b ch0 bouncing does not disturb ch1 press/hold/release timing
    c = cyc;
    key_i = 2'b01;
    push_ev(c + LAT, 2'b10, 2'b00, 2'b00, 2'b01);
    push_ev(c + LAT + 9, 2'b00, 2'b00, 2'b10, 2'b01);
    tick(1);
    key_i = 2'b00;
    tick(1);
    key_i = 2'b01;
    tick(1);
    key_i = 2'b00;
    tick(1);
    key_i = 2'b01;
    tick(12);
    c = cyc;
    key_i = 2'b11;
    push_ev(c + LAT, 2'b00, 2'b10, 2'b00, 2'b11);
    tick(LAT + 4);

    // 6 Reset with a pending count of 2 on ch0
    key_i = 2'b10;
    tick(4);
    sys_rst = 1'b1;
    #1;
    check("midrst_key_o", 32'(key_o), 32'h3);
    check("midrst_pulses", 32'({key_press, key_rel, key_hold}), 32'h0);
    tick(2);
    key_i = 2'b11;
    tick(1);
    sys_rst = 1'b0;
    tick(LAT + 4);
    check("after_rst_key_o", 32'(key_o), 32'h3);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
